// File: rtl/game_session_ctrl.sv
// Session sequencer between the key inputs, game_logic and the renderer.
// Walks clear -> title -> play <-> pause -> over/won -> clear, drives the
// game_logic reset and update enable, picks the screen overlay and latches
// the last and best score. Single clock domain (vga_clk).
//
// Ports:
//   vga_clk     pixel clock, sole clock
//   reset       synchronous active-high reset
//   upd_tick    one-cycle pulse per game update
//   key_any     OR of direction keys (synchronised level)
//   key_pause   pause key (synchronised level)
//   game_over   collision level from game_logic
//   game_won    max-tail level from game_logic
//   tail_count  current score from game_logic
//   game_rst    reset to game_logic
//   game_run    update enable to game_logic
//   screen_sel  overlay: 00 title, 01 play, 10 over, 11 won
//   paused      high while paused
//   last_score  score latched at the end of the last game
//   best_score  maximum last_score since reset
module game_session_ctrl #(
  parameter int unsigned TAIL_W      = 8,
  parameter int unsigned CLEAR_TICKS = 2,
  parameter int unsigned HOLD_TICKS  = 60,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              upd_tick,
  input  logic              key_any,
  input  logic              key_pause,
  input  logic              game_over,
  input  logic              game_won,
  input  logic [TAIL_W-1:0] tail_count,
  output logic              game_rst,
  output logic              game_run,
  output logic [1:0]        screen_sel,
  output logic              paused,
  output logic [TAIL_W-1:0] last_score,
  output logic [TAIL_W-1:0] best_score
);

  typedef enum logic [2:0] {
    StClear,
    StTitle,
    StPlay,
    StPause,
    StOver,
    StWon
  } state_e;

  localparam logic [CNT_W-1:0] ClearCnt = CNT_W'(CLEAR_TICKS);
  localparam logic [CNT_W-1:0] HoldCnt  = CNT_W'(HOLD_TICKS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              key_any_q, key_pause_q;
  logic              any_rise, pause_rise;
  logic [TAIL_W-1:0] last_q, last_d;
  logic [TAIL_W-1:0] best_q, best_d;
  logic              game_rst_q, game_rst_d;
  logic              game_run_q, game_run_d;
  logic [1:0]        screen_sel_q, screen_sel_d;
  logic              paused_q, paused_d;

  // Edge registers run in every state so a key held across a state change
  // never fires in the new state.
  assign any_rise   = key_any & ~key_any_q;
  assign pause_rise = key_pause & ~key_pause_q;
  assign cnt_inc    = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    best_d  = best_q;

    case (state_q)
      StClear: begin
        if (upd_tick) begin
          if (cnt_inc == ClearCnt) begin
            cnt_d   = '0;
            state_d = StTitle;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StTitle: begin
        if (any_rise) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (game_won || game_over) begin
          state_d = game_won ? StWon : StOver;
          last_d  = tail_count;
          best_d  = (tail_count > best_q) ? tail_count : best_q;
          cnt_d   = '0;
        end else if (pause_rise) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (pause_rise) begin
          state_d = StPlay;
        end
      end
      StOver, StWon: begin
        // Rises before the hold expires are simply dropped.
        if (any_rise && (cnt_q == HoldCnt)) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (upd_tick && (cnt_q != HoldCnt)) begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = StClear;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so they move in
  // the same cycle as the state register.
  always_comb begin
    game_rst_d   = 1'b0;
    game_run_d   = 1'b0;
    screen_sel_d = 2'b00;
    paused_d     = 1'b0;
    case (state_d)
      StClear, StTitle: game_rst_d = 1'b1;
      StPlay: begin
        game_run_d   = 1'b1;
        screen_sel_d = 2'b01;
      end
      StPause: begin
        paused_d     = 1'b1;
        screen_sel_d = 2'b01;
      end
      StOver:  screen_sel_d = 2'b10;
      StWon:   screen_sel_d = 2'b11;
      default: game_rst_d = 1'b1;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q      <= StClear;
      cnt_q        <= '0;
      key_any_q    <= 1'b0;
      key_pause_q  <= 1'b0;
      last_q       <= '0;
      best_q       <= '0;
      game_rst_q   <= 1'b1;
      game_run_q   <= 1'b0;
      screen_sel_q <= 2'b00;
      paused_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_any_q    <= key_any;
      key_pause_q  <= key_pause;
      last_q       <= last_d;
      best_q       <= best_d;
      game_rst_q   <= game_rst_d;
      game_run_q   <= game_run_d;
      screen_sel_q <= screen_sel_d;
      paused_q     <= paused_d;
    end
  end

  assign game_rst   = game_rst_q;
  assign game_run   = game_run_q;
  assign screen_sel = screen_sel_q;
  assign paused     = paused_q;
  assign last_score = last_q;
  assign best_score = best_q;

endmodule
